// File: rtl/pll_sup_pkg.sv
// Shared state encodings and counter-width helper for the PLL supervisor.
package pll_sup_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RESET_PLL = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_RELEASE   = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_FAIL      = 3'd4;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int unsigned max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_sync_filter.sv
// Brings the asynchronous PLL LOCK into clkin and qualifies it with a
// consecutive-high filter that saturates at LOCK_FILT.
module lock_sync_filter
  import pll_sup_pkg::*;
#(
  parameter int LOCK_FILT = 64
) (
  input  logic clkin,
  input  logic rst,
  input  logic lock_async_i,
  input  logic clr_i,
  output logic lock_s_o,
  output logic lock_ok_o
);

  localparam int FW = cnt_width(LOCK_FILT);
  localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILT);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [FW-1:0] filt_q, filt_d;

  always_comb begin
    sync1_d = lock_async_i;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    if (clr_i || !sync2_q) begin
      filt_d = '0;
    end else if (filt_q != FILT_MAX) begin
      filt_d = filt_q + 1'b1;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
    end
  end

  assign lock_s_o  = sync2_q;
  assign lock_ok_o = (filt_q == FILT_MAX);

endmodule

// File: rtl/pll_supervisor.sv
// PLL bring-up sequencer: pulses PLL RESET, waits for a filtered lock with
// retries, then releases the downstream domain resets one after another.
module pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_FILT    = 64,
  parameter int LOCK_TIMEOUT = 2400000,
  parameter int STAGGER      = 8,
  parameter int RETRY_MAX    = 7,
  parameter int CNT_W        = 8
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              pll_lock_i,
  input  logic              relock_req_i,
  output logic              pll_reset_o,
  output logic [NUM_CH-1:0] chan_rst_o,
  output logic              ready_o,
  output logic              fail_o,
  output logic [CNT_W-1:0]  relock_cnt_o,
  output logic [2:0]        state_o
);

  localparam int RW = cnt_width(PLL_RST_CYC);
  localparam int TW = cnt_width(LOCK_TIMEOUT);
  localparam int SW = cnt_width(STAGGER * NUM_CH);
  localparam int YW = cnt_width(RETRY_MAX);

  localparam logic [RW-1:0]    RST_LAST  = RW'(PLL_RST_CYC - 1);
  localparam logic [TW-1:0]    TO_MAX    = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0]    STG_LAST  = SW'(STAGGER * NUM_CH);
  localparam logic [YW-1:0]    RETRY_LIM = YW'(RETRY_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic              pll_reset_q, pll_reset_d;
  logic [NUM_CH-1:0] chan_rst_q, chan_rst_d;
  logic              ready_q, ready_d;
  logic              fail_q, fail_d;
  logic [CNT_W-1:0]  relock_cnt_q, relock_cnt_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [SW-1:0]     stg_q, stg_d;
  logic [YW-1:0]     retry_q, retry_d;

  logic          lock_s, lock_ok;
  logic          go_reset;
  logic [TW-1:0] to_next;
  logic [SW-1:0] stg_next;
  logic [YW-1:0] retry_next;

  lock_sync_filter #(
    .LOCK_FILT(LOCK_FILT)
  ) u_lock (
    .clkin       (clkin),
    .rst         (rst),
    .lock_async_i(pll_lock_i),
    .clr_i       (state_q == ST_RESET_PLL),
    .lock_s_o    (lock_s),
    .lock_ok_o   (lock_ok)
  );

  // Event priority: software request, then lock loss, then per-state progress.
  always_comb begin
    state_d      = state_q;
    pll_reset_d  = pll_reset_q;
    chan_rst_d   = chan_rst_q;
    ready_d      = ready_q;
    fail_d       = fail_q;
    relock_cnt_d = relock_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    to_cnt_d     = to_cnt_q;
    stg_d        = stg_q;
    retry_d      = retry_q;
    go_reset     = 1'b0;
    to_next      = to_cnt_q + 1'b1;
    stg_next     = stg_q + 1'b1;
    retry_next   = retry_q + 1'b1;

    if (relock_req_i) begin
      go_reset = 1'b1;
      retry_d  = '0;
      fail_d   = 1'b0;
    end else if ((state_q == ST_RELEASE || state_q == ST_RUN) && !lock_s) begin
      go_reset = 1'b1;
      if (relock_cnt_q != CNT_MAX) relock_cnt_d = relock_cnt_q + 1'b1;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d     = ST_WAIT_LOCK;
            pll_reset_d = 1'b0;
            rst_cnt_d   = '0;
            to_cnt_d    = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_ok) begin
            state_d = ST_RELEASE;
            stg_d   = '0;
          end else if (to_next == TO_MAX) begin
            retry_d = retry_next;
            if (retry_next == RETRY_LIM) begin
              state_d     = ST_FAIL;
              pll_reset_d = 1'b1;
              fail_d      = 1'b1;
            end else begin
              go_reset = 1'b1;
            end
          end else begin
            to_cnt_d = to_next;
          end
        end
        ST_RELEASE: begin
          if (stg_q == STG_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
            retry_d = '0;
          end else begin
            stg_d = stg_next;
            // Channel k drops once the count reaches STAGGER*(k+1).
            for (int k = 0; k < NUM_CH; k++) begin
              chan_rst_d[k] = (stg_next < SW'(STAGGER * (k + 1)));
            end
          end
        end
        ST_RUN, ST_FAIL: begin
        end
        default: go_reset = 1'b1;
      endcase
    end

    if (go_reset) begin
      state_d     = ST_RESET_PLL;
      pll_reset_d = 1'b1;
      chan_rst_d  = '1;
      ready_d     = 1'b0;
      rst_cnt_d   = '0;
      to_cnt_d    = '0;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RESET_PLL;
      pll_reset_q  <= 1'b1;
      chan_rst_q   <= '1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
      relock_cnt_q <= '0;
      rst_cnt_q    <= '0;
      to_cnt_q     <= '0;
      stg_q        <= '0;
      retry_q      <= '0;
    end else begin
      state_q      <= state_d;
      pll_reset_q  <= pll_reset_d;
      chan_rst_q   <= chan_rst_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
      relock_cnt_q <= relock_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      to_cnt_q     <= to_cnt_d;
      stg_q        <= stg_d;
      retry_q      <= retry_d;
    end
  end

  assign pll_reset_o  = pll_reset_q;
  assign chan_rst_o   = chan_rst_q;
  assign ready_o      = ready_q;
  assign fail_o       = fail_q;
  assign relock_cnt_o = relock_cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench for pll_supervisor: the stimulus thread queues cycle-stamped
// expected output snapshots, the negedge monitor pops and compares them.
module tb_pll_supervisor;

  logic       clkin;
  logic       rst;
  logic       pll_lock_i;
  logic       relock_req_i;
  logic       pll_reset_o;
  logic [2:0] chan_rst_o;
  logic       ready_o;
  logic       fail_o;
  logic [3:0] relock_cnt_o;
  logic [2:0] state_o;

  typedef struct {
    string       name;
    int          cyc;
    logic [12:0] vec;
  } exp_t;

  exp_t expQ[$];
  int   cyc       = 0;
  int   nCompared = 0;
  int   nMismatch = 0;

  pll_supervisor #(
    .NUM_CH      (3),
    .PLL_RST_CYC (4),
    .LOCK_FILT   (8),
    .LOCK_TIMEOUT(100),
    .STAGGER     (3),
    .RETRY_MAX   (2),
    .CNT_W       (4)
  ) dut (
    .clkin       (clkin),
    .rst         (rst),
    .pll_lock_i  (pll_lock_i),
    .relock_req_i(relock_req_i),
    .pll_reset_o (pll_reset_o),
    .chan_rst_o  (chan_rst_o),
    .ready_o     (ready_o),
    .fail_o      (fail_o),
    .relock_cnt_o(relock_cnt_o),
    .state_o     (state_o)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Edge counter: after posedge n (and at the following negedge) cyc == n.
  always @(posedge clkin) cyc <= cyc + 1;

  function automatic logic [12:0] mk(input logic [2:0] st, input logic pr,
                                     input logic [2:0] ch, input logic rd,
                                     input logic fl, input logic [3:0] cnt);
    return {st, pr, ch, rd, fl, cnt};
  endfunction

  task automatic pushExp(input string name, input int at, input logic [12:0] vec);
    exp_t e;
    e.name = name;
    e.cyc  = at;
    e.vec  = vec;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic lk, input logic rq);
    pll_lock_i   = lk;
    relock_req_i = rq;
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [12:0] act;
    logic [12:0] req;
    act = {state_o, pll_reset_o, chan_rst_o, ready_o, fail_o, relock_cnt_o};
    req = e.vec;
    nCompared++;
    if (act !== req) begin
      nMismatch++;
      $display("[TB] FAIL %s @cyc %0d: got st=%0d prst=%b chan=%b rdy=%b fail=%b cnt=%0d, need st=%0d prst=%b chan=%b rdy=%b fail=%b cnt=%0d",
               e.name, cyc, act[12:10], act[9], act[8:6], act[5], act[4], act[3:0],
               req[12:10], req[9], req[8:6], req[5], req[4], req[3:0]);
    end
  endtask

  always @(negedge clkin) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached with %0d checks pending", expQ.size());
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0, lk, s, r, g, d, f, t, expCnt;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clkin);
    #1;
    pushExp("reset_hold", cyc, mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0));
    waitCyc(cyc + 1);

    // Nominal bring-up
    c0 = cyc;
    pushExp("reset_vals",   c0,     mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0));
    rst = 1'b0;
    pushExp("pll_rst_last", c0 + 3, mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0));
    pushExp("wait_lock",    c0 + 4, mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    lk = c0 + 20;
    s  = lk + 11;
    waitCyc(lk);
    applyStimulus(1'b1, 1'b0);
    pushExp("pre_release",  s - 1,  mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    pushExp("release_in",   s,      mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    pushExp("ch0_hold",     s + 2,  mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    pushExp("ch0_fall",     s + 3,  mk(3'd2, 1'b0, 3'b110, 1'b0, 1'b0, 4'd0));
    pushExp("ch1_hold",     s + 5,  mk(3'd2, 1'b0, 3'b110, 1'b0, 1'b0, 4'd0));
    pushExp("ch1_fall",     s + 6,  mk(3'd2, 1'b0, 3'b100, 1'b0, 1'b0, 4'd0));
    pushExp("ch2_hold",     s + 8,  mk(3'd2, 1'b0, 3'b100, 1'b0, 1'b0, 4'd0));
    pushExp("ch2_fall",     s + 9,  mk(3'd2, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0));
    pushExp("run_ready",    s + 10, mk(3'd3, 1'b0, 3'b000, 1'b1, 1'b0, 4'd0));

    // Lock loss in RUN
    d = s + 14;
    waitCyc(d);
    applyStimulus(1'b0, 1'b0);
    pushExp("run_pre_loss", d + 2,  mk(3'd3, 1'b0, 3'b000, 1'b1, 1'b0, 4'd0));
    pushExp("loss_in_run",  d + 3,  mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd1));

    // Glitch in WAIT_LOCK delays RELEASE
    r = d + 3;
    g = r + 6;
    waitCyc(g);
    applyStimulus(1'b1, 1'b0);
    pushExp("glitch_no_early", g + 11, mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd1));
    pushExp("glitch_wait",     g + 16, mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd1));
    pushExp("glitch_release",  g + 17, mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 4'd1));
    s = g + 17;
    pushExp("mid_rel_ch0",     s + 3,  mk(3'd2, 1'b0, 3'b110, 1'b0, 1'b0, 4'd1));
    pushExp("mid_rel_pre",     s + 5,  mk(3'd2, 1'b0, 3'b110, 1'b0, 1'b0, 4'd1));
    pushExp("mid_rel_loss",    s + 6,  mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd2));
    waitCyc(g + 5);
    applyStimulus(1'b0, 1'b0);
    waitCyc(g + 6);
    applyStimulus(1'b1, 1'b0);

    // Lock loss mid-RELEASE after channel 0 is out of reset
    waitCyc(s + 3);
    applyStimulus(1'b0, 1'b0);

    // Relock request coinciding with lock loss
    r = s + 6;
    waitCyc(r + 5);
    applyStimulus(1'b1, 1'b0);
    pushExp("run_again",    r + 26, mk(3'd3, 1'b0, 3'b000, 1'b1, 1'b0, 4'd2));
    d = r + 30;
    waitCyc(d);
    applyStimulus(1'b0, 1'b0);
    pushExp("req_pre",      d + 2,  mk(3'd3, 1'b0, 3'b000, 1'b1, 1'b0, 4'd2));
    pushExp("req_and_loss", d + 3,  mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd2));
    pushExp("req_after",    d + 4,  mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd2));
    waitCyc(d + 2);
    applyStimulus(1'b0, 1'b1);
    waitCyc(d + 3);
    applyStimulus(1'b0, 1'b0);

    // Timeout, retry, FAIL and recovery by request
    r = d + 3;
    pushExp("to_last_wait", r + 103, mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd2));
    pushExp("retry_reset",  r + 104, mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd2));
    pushExp("retry_rst_end",r + 107, mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd2));
    pushExp("retry_wait",   r + 108, mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd2));
    pushExp("to2_last",     r + 207, mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd2));
    pushExp("fail_enter",   r + 208, mk(3'd4, 1'b1, 3'b111, 1'b0, 1'b1, 4'd2));
    pushExp("fail_hold",    r + 215, mk(3'd4, 1'b1, 3'b111, 1'b0, 1'b1, 4'd2));
    f = r + 215;
    waitCyc(f);
    applyStimulus(1'b0, 1'b1);
    pushExp("req_from_fail", f + 1, mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd2));
    waitCyc(f + 1);
    applyStimulus(1'b0, 1'b0);

    // Repeated losses until the event counter saturates
    r = f + 1;
    expCnt = 2;
    for (int i = 0; i < 16; i++) begin
      waitCyc(r + 5);
      applyStimulus(1'b1, 1'b0);
      pushExp("sat_release", r + 16, mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 4'(expCnt)));
      waitCyc(r + 16);
      applyStimulus(1'b0, 1'b0);
      if (expCnt < 15) expCnt = expCnt + 1;
      pushExp("sat_loss", r + 19, mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'(expCnt)));
      r = r + 19;
    end

    // Asynchronous reset pulse between edges while in RUN
    waitCyc(r + 5);
    applyStimulus(1'b1, 1'b0);
    pushExp("run_pre_rst", r + 26, mk(3'd3, 1'b0, 3'b000, 1'b1, 1'b0, 4'd15));
    t = r + 30;
    waitCyc(t);
    pushExp("async_rst",    t,      mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0));
    pushExp("rst_pll_last", t + 3,  mk(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0));
    pushExp("rst_wait",     t + 4,  mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    pushExp("rst_pre_rel",  t + 12, mk(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    pushExp("rst_release",  t + 13, mk(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    rst = 1'b1;
    #2;
    rst = 1'b0;
    waitCyc(t + 15);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clkin);
    #1;
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL %s: check for cycle %0d never reached, got nothing, need a sample", e.name, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
